// File: rtl/heartbeat_pkg.sv
// Shared types and helpers for the heartbeat watchdog: channel state encoding,
// fault-count width and the saturating counter increment.
package heartbeat_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        FAULT = 2'd1,
        ALIVE = 2'd2
    } ch_state_e;

    localparam int FCNT_W = 8;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == {FCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hb_channel.sv
// One heartbeat channel: 2-flop beat synchroniser, edge detect, WAIT/FAULT/ALIVE FSM,
// tick counter, sticky fault flag and saturating fault count. Edge-to-state latency 3 cycles; no backpressure.
module hb_channel
    import heartbeat_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 150
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              beat_i,
    input  logic              en_i,
    input  logic              tick_i,
    input  logic              fault_clr_i,
    output logic              alive_o,
    output logic              fault_sticky_o,
    output logic [FCNT_W-1:0] fault_count_o,
    output logic              hbeat_o
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS);

    logic              beat_meta_q, beat_sync_q, beat_last_q;
    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              sticky_q, sticky_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              hbeat_q, hbeat_d;
    logic              beat_edge, timeout;

    assign beat_edge = beat_sync_q ^ beat_last_q;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hbeat_d  = hbeat_q;
        timeout  = 1'b0;
        if (!en_i) begin
            state_d = WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (tick_i) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = FAULT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                FAULT: begin
                    if (beat_edge) begin
                        state_d = ALIVE;
                        cnt_d   = '0;
                        hbeat_d = ~hbeat_q;
                    end
                end
                ALIVE: begin
                    // An edge in the same cycle as the expiring tick keeps the channel alive.
                    if (beat_edge) begin
                        cnt_d   = '0;
                        hbeat_d = ~hbeat_q;
                    end else if (tick_i) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = FAULT;
                            cnt_d   = '0;
                            timeout = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            endcase
        end

        sticky_d = sticky_q;
        fcnt_d   = fcnt_q;
        if (timeout) begin
            sticky_d = 1'b1;
            fcnt_d   = fault_clr_i ? FCNT_W'(1) : sat_inc(fcnt_q);
        end else if (fault_clr_i) begin
            sticky_d = 1'b0;
            fcnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_meta_q <= 1'b0;
            beat_sync_q <= 1'b0;
            beat_last_q <= 1'b0;
            state_q     <= WAIT;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            fcnt_q      <= '0;
            hbeat_q     <= 1'b0;
        end else begin
            beat_meta_q <= beat_i;
            beat_sync_q <= beat_meta_q;
            beat_last_q <= beat_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            fcnt_q      <= fcnt_d;
            hbeat_q     <= hbeat_d;
        end
    end

    assign alive_o        = (state_q == ALIVE);
    assign fault_sticky_o = sticky_q;
    assign fault_count_o  = fcnt_q;
    assign hbeat_o        = hbeat_q;

endmodule

// File: rtl/heartbeat_watchdog.sv
// Multi-channel heartbeat watchdog gating the motor reset tree: prescaler, e_stop sync, output_reset register.
// rst->output_reset 1 cycle, e_stop 3 cycles, beat 4 cycles; no backpressure (pure pass/force).
module heartbeat_watchdog
    import heartbeat_pkg::*;
#(
    parameter int TICK_DIV      = 5000,
    parameter int TIMEOUT_TICKS = 150,
    parameter int NUM_CH        = 4,
    parameter int RST_W         = 32
) (
    input  logic                     clk_50Mhz,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        beat,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [RST_W-1:0]         rst,
    input  logic                     e_stop,
    input  logic                     fault_clr,
    output logic [RST_W-1:0]         output_reset,
    output logic [NUM_CH-1:0]        alive,
    output logic [NUM_CH-1:0]        fault_sticky,
    output logic [NUM_CH*FCNT_W-1:0] fault_count,
    output logic                     tick_out,
    output logic                     gpio_out100hz,
    output logic [NUM_CH-1:0]        hbeat_out
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic             gpio_q;
    logic             estop_meta_q, estop_sync_q;
    logic [RST_W-1:0] out_rst_q, out_rst_d;
    logic             healthy;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hb_channel #(
            .TIMEOUT_TICKS(TIMEOUT_TICKS)
        ) u_ch (
            .clk_i         (clk_50Mhz),
            .rst_ni        (reset_n),
            .beat_i        (beat[i]),
            .en_i          (ch_en[i]),
            .tick_i        (tick),
            .fault_clr_i   (fault_clr),
            .alive_o       (alive[i]),
            .fault_sticky_o(fault_sticky[i]),
            .fault_count_o (fault_count[i*FCNT_W +: FCNT_W]),
            .hbeat_o       (hbeat_out[i])
        );
    end

    // Disabled channels count as healthy, but at least one channel must be enabled.
    assign healthy = (|ch_en) && (&(alive | ~ch_en)) && !estop_sync_q;

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        out_rst_d = healthy ? rst : '1;
    end

    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            gpio_q       <= 1'b0;
            estop_meta_q <= 1'b0;
            estop_sync_q <= 1'b0;
            out_rst_q    <= '1;
        end else begin
            presc_q      <= presc_d;
            gpio_q       <= gpio_q ^ tick;
            estop_meta_q <= e_stop;
            estop_sync_q <= estop_meta_q;
            out_rst_q    <= out_rst_d;
        end
    end

    assign output_reset  = out_rst_q;
    assign tick_out      = tick;
    assign gpio_out100hz = gpio_q;

endmodule

// File: tb/tb_heartbeat_watchdog.sv
// Directed bench for heartbeat_watchdog: a table of timed vectors for the main
// alive/timeout/e_stop flow, then hand sequences for clear, saturation and reset.
module tb_heartbeat_watchdog;

    logic        clk_50Mhz = 1'b0;
    logic        reset_n;
    logic [1:0]  beat, ch_en;
    logic [7:0]  rst;
    logic        e_stop, fault_clr;
    logic [7:0]  output_reset;
    logic [1:0]  alive, fault_sticky, hbeat_out;
    logic [15:0] fault_count;
    logic        tick_out, gpio_out100hz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    heartbeat_watchdog #(
        .TICK_DIV(4), .TIMEOUT_TICKS(5), .NUM_CH(2), .RST_W(8)
    ) dut (
        .clk_50Mhz    (clk_50Mhz),
        .reset_n      (reset_n),
        .beat         (beat),
        .ch_en        (ch_en),
        .rst          (rst),
        .e_stop       (e_stop),
        .fault_clr    (fault_clr),
        .output_reset (output_reset),
        .alive        (alive),
        .fault_sticky (fault_sticky),
        .fault_count  (fault_count),
        .tick_out     (tick_out),
        .gpio_out100hz(gpio_out100hz),
        .hbeat_out    (hbeat_out)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    typedef struct {
        int          cyc;
        logic [1:0]  beat;
        logic        es;
        logic [7:0]  e_out;
        logic [1:0]  e_alive;
        logic [1:0]  e_sticky;
        logic [1:0]  e_hb;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input int c, input logic [1:0] b, input logic es,
                                input logic [7:0] o, input logic [1:0] a,
                                input logic [1:0] s, input logic [1:0] h,
                                input logic [15:0] f);
        vec_t v;
        v.cyc = c; v.beat = b; v.es = es; v.e_out = o;
        v.e_alive = a; v.e_sticky = s; v.e_hb = h; v.e_fc = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Advance to just after rising edge number 'target' since reset release.
    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(posedge clk_50Mhz);
            #1;
            cyc++;
        end
    endtask

    initial begin
        //            cyc  beat   es    out    alive  sticky hbeat  fcount
        tbl[0]  = mk(19, 2'b00, 1'b0, 8'hFF, 2'b00, 2'b00, 2'b00, 16'h0000);
        tbl[1]  = mk(21, 2'b00, 1'b0, 8'hFF, 2'b00, 2'b00, 2'b00, 16'h0000);
        tbl[2]  = mk(24, 2'b11, 1'b0, 8'hFF, 2'b11, 2'b00, 2'b11, 16'h0000);
        tbl[3]  = mk(25, 2'b11, 1'b0, 8'h5A, 2'b11, 2'b00, 2'b11, 16'h0000);
        tbl[4]  = mk(29, 2'b11, 1'b0, 8'h5A, 2'b11, 2'b00, 2'b11, 16'h0000);
        tbl[5]  = mk(37, 2'b10, 1'b0, 8'h5A, 2'b11, 2'b00, 2'b10, 16'h0000);
        tbl[6]  = mk(43, 2'b11, 1'b0, 8'h5A, 2'b11, 2'b00, 2'b11, 16'h0000);
        tbl[7]  = mk(44, 2'b11, 1'b0, 8'h5A, 2'b01, 2'b10, 2'b11, 16'h0100);
        tbl[8]  = mk(45, 2'b11, 1'b0, 8'hFF, 2'b01, 2'b10, 2'b11, 16'h0100);
        tbl[9]  = mk(48, 2'b01, 1'b0, 8'hFF, 2'b11, 2'b10, 2'b01, 16'h0100);
        tbl[10] = mk(49, 2'b01, 1'b0, 8'h5A, 2'b11, 2'b10, 2'b01, 16'h0100);
        tbl[11] = mk(51, 2'b01, 1'b1, 8'h5A, 2'b11, 2'b10, 2'b01, 16'h0100);
        tbl[12] = mk(52, 2'b01, 1'b1, 8'hFF, 2'b11, 2'b10, 2'b01, 16'h0100);
        tbl[13] = mk(59, 2'b10, 1'b1, 8'hFF, 2'b11, 2'b10, 2'b10, 16'h0100);
        tbl[14] = mk(61, 2'b10, 1'b0, 8'hFF, 2'b11, 2'b10, 2'b10, 16'h0100);
        tbl[15] = mk(62, 2'b10, 1'b0, 8'h5A, 2'b11, 2'b10, 2'b10, 16'h0100);

        reset_n = 1'b0; beat = 2'b00; ch_en = 2'b11; rst = 8'h5A;
        e_stop = 1'b0; fault_clr = 1'b0;
        repeat (2) @(posedge clk_50Mhz);
        #1;
        chk("rst out",    32'(output_reset),  32'hFF);
        chk("rst alive",  32'(alive),         32'h0);
        chk("rst sticky", 32'(fault_sticky),  32'h0);
        chk("rst fcnt",   32'(fault_count),   32'h0);
        chk("rst hbeat",  32'(hbeat_out),     32'h0);
        chk("rst tick",   32'(tick_out),      32'h0);
        chk("rst gpio",   32'(gpio_out100hz), 32'h0);
        #4 reset_n = 1'b1;
        cyc = 0;

        for (int i = 0; i < 16; i++) begin
            beat   = tbl[i].beat;
            e_stop = tbl[i].es;
            adv_to(tbl[i].cyc);
            chk($sformatf("row%0d out", i),    32'(output_reset), 32'(tbl[i].e_out));
            chk($sformatf("row%0d alive", i),  32'(alive),        32'(tbl[i].e_alive));
            chk($sformatf("row%0d sticky", i), 32'(fault_sticky), 32'(tbl[i].e_sticky));
            chk($sformatf("row%0d hbeat", i),  32'(hbeat_out),    32'(tbl[i].e_hb));
            chk($sformatf("row%0d fcnt", i),   32'(fault_count),  32'(tbl[i].e_fc));
        end

        // ch1 times out at cycle 72 with fault_clr pulsed in that same cycle
        beat = 2'b11;
        adv_to(71);
        fault_clr = 1'b1;
        adv_to(72);
        fault_clr = 1'b0;
        chk("clr+to alive",  32'(alive),        32'h1);
        chk("clr+to sticky", 32'(fault_sticky), 32'h2);
        chk("clr+to fcnt",   32'(fault_count),  32'h0100);
        chk("clr+to out",    32'(output_reset), 32'h5A);
        adv_to(73);
        chk("to out ff",     32'(output_reset), 32'hFF);
        adv_to(84);
        chk("ch0 to alive",  32'(alive),        32'h0);
        chk("ch0 to sticky", 32'(fault_sticky), 32'h3);
        chk("ch0 to fcnt",   32'(fault_count),  32'h0101);
        adv_to(85);
        fault_clr = 1'b1;
        adv_to(86);
        fault_clr = 1'b0;
        chk("clr sticky", 32'(fault_sticky), 32'h0);
        chk("clr fcnt",   32'(fault_count),  32'h0);

        // each 24-cycle round yields exactly one timeout on both channels
        for (int k = 0; k < 300; k++) begin
            beat = ~beat;
            adv_to(cyc + 24);
            if (k == 9) begin
                chk("fcnt 10",   32'(fault_count),  32'h0A0A);
                chk("sticky 10", 32'(fault_sticky), 32'h3);
            end
        end
        chk("fcnt sat", 32'(fault_count), 32'hFFFF);

        beat = ~beat;
        adv_to(cyc + 4);
        chk("alive again", 32'(alive),        32'h3);
        chk("out again",   32'(output_reset), 32'h5A);
        rst = 8'h3C;
        adv_to(cyc + 1);
        chk("rst follow",  32'(output_reset), 32'h3C);

        #1 reset_n = 1'b0;
        #1;
        chk("async out",    32'(output_reset), 32'hFF);
        chk("async alive",  32'(alive),        32'h0);
        chk("async sticky", 32'(fault_sticky), 32'h0);
        chk("async fcnt",   32'(fault_count),  32'h0);
        #2 reset_n = 1'b1;
        ch_en = 2'b01;
        cyc = 0;
        adv_to(2);
        chk("tick c2",  32'(tick_out),      32'h0);
        adv_to(3);
        chk("tick c3",  32'(tick_out),      32'h1);
        chk("gpio c3",  32'(gpio_out100hz), 32'h0);
        adv_to(4);
        chk("tick c4",  32'(tick_out),      32'h0);
        chk("gpio c4",  32'(gpio_out100hz), 32'h1);
        adv_to(21);
        chk("en01 wait alive", 32'(alive),        32'h0);
        chk("en01 wait out",   32'(output_reset), 32'hFF);
        beat[0] = ~beat[0];
        adv_to(24);
        chk("en01 alive",    32'(alive),        32'h1);
        chk("en01 out pre",  32'(output_reset), 32'hFF);
        adv_to(25);
        chk("en01 out",      32'(output_reset), 32'h3C);
        ch_en = 2'b00;
        adv_to(26);
        chk("en00 out",   32'(output_reset), 32'hFF);
        chk("en00 alive", 32'(alive),        32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
